crtc_port_sched: RTL
====================

# crtc_port_sched

Sequencer and arbiter for the UM6845R CPU register port. Three requesters share the port: the Z80 I/O decode, the Plus ASIC, and a built-in preset loader that programs registers 0..NREGS-1 from an external table. Every access is issued as a single-CLOCK strobe at the CRTC character rate. The block tracks the CRTC's one address latch and re-selects a requester's register before its data access whenever another requester has moved the latch.

## Interface
- NREGS, 16: number of registers the preset loader writes (1..16).
- CLOCK  in  1  system clock.
- nRESET  in  1  synchronous, active-low reset.
- CLKEN  in  1  CRTC character clock enable; successive pulses are at least 3 CLOCKs apart.
- cpu_req  in  1  Z80 access request (level); held until cpu_ack.
- cpu_rs, cpu_rnw  in  1 each  register select / read-not-write for the Z80 access.
- cpu_di  in  8  Z80 write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_do  out  8  read data; valid with cpu_ack and held until the next cpu read.
- plus_en  in  1  Plus mode; when 0, plus_req is ignored.
- plus_req, plus_rs, plus_rnw, plus_di[7:0], plus_ack, plus_do[7:0]  same semantics as the cpu_* signals, for the Plus ASIC.
- preset_start  in  1  pulse that starts the preset load.
- preset_busy  out  1  high while the preset load is in progress.
- preset_done  out  1  one-cycle pulse after the final preset write.
- preset_idx  out  4  table index; the table is combinational.
- preset_data  in  8  table value at preset_idx.
- crtc_enable, crtc_ncs, crtc_rnw, crtc_rs  out  1 each  drive the CRTC ENABLE, nCS, R_nW and RS inputs.
- crtc_di  out  8  drives the CRTC DI input.
- crtc_do  in  8  CRTC DO output; combinational while it is strobed.

## Operation
- **Slots.** A slot decision is made only in CLKEN cycles, at most one access per slot.
- **Slot priority:** pending PRESET_DATA, then address restore, then cpu, then plus, then PRESET_ADDR.
- **Shadow state.**
  - Registered shadow addresses: sh_cpu[4:0], sh_plus[4:0].
  - cur_addr[4:0] plus cur_valid: what the CRTC latch holds.
- **Address write (rs=0).**
  - Issued directly; the write is RS=0 with DI = di.
  - sh_r <= di[4:0], cur_addr <= di[4:0], cur_valid <= 1, ack.
- **Data access (rs=1).**
  - If !cur_valid or sh_r != cur_addr: the slot issues a restore (RS=0, R_nW=0, DI={3'b0,sh_r}) and sets cur_addr <= sh_r, cur_valid <= 1, with no ack. The access itself goes in a later slot.
  - Otherwise: RS=1, R_nW = rnw, DI = di, then ack.
  - A restore owner keeps the next slot; cpu/plus priority does not preempt it.
- **Preset FSM states:** P_IDLE, P_ADDR, P_DATA.
  - P_IDLE: preset_start moves to P_ADDR with idx <= 0 and busy <= 1. preset_start is ignored in any other state.
  - P_ADDR: when granted a slot, issue RS=0, DI=idx, set cur_addr <= idx, go to P_DATA.
  - P_DATA: takes the very next slot unconditionally, so the pair is atomic. Issue RS=1, DI=preset_data.
  - After P_DATA: if idx == NREGS-1, go to P_IDLE, drop busy, pulse done. Otherwise idx <= idx+1 and go to P_ADDR.
- cpu and plus may win slots between preset pairs; the restore logic repairs the latch.
- A read returns crtc_do sampled at the end of the strobe cycle.

## Timing
- Slot decided in CLKEN cycle T.
- Strobe (crtc_enable=1, crtc_ncs=0, plus rnw/rs/di) is registered and presented for exactly one cycle, T+1. Outside strobes the outputs are idle.
- ack pulses in T+2; do is updated in T+2 for reads.
- req is sampled only in CLKEN cycles. A requester drops req or changes the request no later than the cycle after ack. A request still high at the next CLKEN after ack is treated as a new access.
- A rs=1 access with a stale latch takes 2 slots (restore + access); ack comes 2 slots later.
- preset_done pulses in the T+2 of the final data slot.
- Full load with no contention: 2*NREGS slots.
- **Simultaneous requests:**
  - cpu and plus together: cpu is served, plus waits.
  - preset_start together with any request: the request is served first and preset_busy rises in T+1.
- **Reset values:** crtc_enable=0, crtc_ncs=1, crtc_rnw=1, crtc_rs=0, crtc_di=0, both acks 0, both do 0, preset_busy=0, preset_done=0, preset_idx=0, sh_*=0, cur_valid=0, FSM in P_IDLE.
- **Reset mid-operation:** aborts the load and drops any pending request or restore, with no ack and no done. The outputs are at their reset values in the following cycle.

## Test plan
- **Preset load:** reset, then preset_start with table[i]=0x10+i and NREGS=16, no other traffic. Expect 32 strobes in strobe order RS=0/DI=i then RS=1/DI=0x10+i, one preset_done, preset_busy high for exactly 32 slots.
- **CPU address then data:** cpu address write 0x0C, then data write 0x30. Expect 2 strobes with no restore, a cpu_ack for each in T+2, and no strobe in any non-CLKEN-aligned cycle.
- **Restore after preset moves the latch:** cpu selects reg 7; a preset pair for reg 3 runs; cpu writes data 0x1E. Expect strobes RS=0/DI=7 (restore, no ack), then RS=1/DI=0x1E, then cpu_ack.
- **Contention:** cpu and plus (plus_en=1) both request data to different registers with a shared latch. Expect cpu served first, then a plus restore, then plus data. With plus_en=0, expect plus never acked.
- **Atomic preset pair:** cpu_req arrives in the slot between P_ADDR and P_DATA. Expect the P_DATA strobe first, then a cpu restore, then the cpu access.
- **Reset during preset and read path:** nRESET low at preset idx 5 gives outputs at reset values with no done. Afterwards, a cpu read of reg 12 with crtc_do=0x00 returns cpu_do=0x00 with cpu_ack.

Source files
------------

// File: rtl/crtc_port_sched.sv
// Arbiter/sequencer for the UM6845R CPU register port: Z80, Plus ASIC and a preset loader share
// one strobe per character slot; the CRTC address latch is tracked and restored when stale.
module crtc_port_sched #(
  parameter int unsigned NREGS = 16
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       cpu_req,
  input  logic       cpu_rs,
  input  logic       cpu_rnw,
  input  logic [7:0] cpu_di,
  output logic       cpu_ack,
  output logic [7:0] cpu_do,
  input  logic       plus_en,
  input  logic       plus_req,
  input  logic       plus_rs,
  input  logic       plus_rnw,
  input  logic [7:0] plus_di,
  output logic       plus_ack,
  output logic [7:0] plus_do,
  input  logic       preset_start,
  output logic       preset_busy,
  output logic       preset_done,
  output logic [3:0] preset_idx,
  input  logic [7:0] preset_data,
  output logic       crtc_enable,
  output logic       crtc_ncs,
  output logic       crtc_rnw,
  output logic       crtc_rs,
  output logic [7:0] crtc_di,
  input  logic [7:0] crtc_do
);

  typedef enum logic [1:0] {PIdle, PAddr, PData} pst_e;
  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnPlus} own_e;

  localparam logic [3:0] LastIdx = 4'(NREGS - 1);

  pst_e       pst_q, pst_d;
  own_e       rest_q, rest_d;
  own_e       sel;
  logic [3:0] idx_q, idx_d;
  logic [4:0] sh_cpu_q, sh_cpu_d, sh_plus_q, sh_plus_d;
  logic [4:0] cur_addr_q, cur_addr_d;
  logic       cur_valid_q, cur_valid_d;

  // Strobe stage: decided in the CLKEN cycle, presented the cycle after.
  logic       stb_q, stb_d, stb_rnw_q, stb_rnw_d, stb_rs_q, stb_rs_d;
  logic [7:0] stb_di_q, stb_di_d;
  logic       ack_cpu_p_q, ack_cpu_p_d, ack_plus_p_q, ack_plus_p_d;
  logic       rd_p_q, rd_p_d, done_p_q, done_p_d;
  logic       cpu_ack_q, plus_ack_q, done_q;
  logic [7:0] cpu_do_q, plus_do_q;

  logic       rq_rs, rq_rnw, give_ack;
  logic [7:0] rq_di;
  logic [4:0] sh_sel;

  always_comb begin
    pst_d       = pst_q;
    rest_d      = rest_q;
    idx_d       = idx_q;
    sh_cpu_d    = sh_cpu_q;
    sh_plus_d   = sh_plus_q;
    cur_addr_d  = cur_addr_q;
    cur_valid_d = cur_valid_q;
    stb_d       = 1'b0;
    stb_rnw_d   = 1'b1;
    stb_rs_d    = 1'b0;
    stb_di_d    = 8'h00;
    rd_p_d      = 1'b0;
    done_p_d    = 1'b0;
    give_ack    = 1'b0;
    sel         = OwnNone;

    if (pst_q == PIdle && preset_start) begin
      pst_d = PAddr;
      idx_d = 4'd0;
    end

    if (CLKEN) begin
      rest_d = OwnNone;
      if (pst_q == PData) begin
        // Data half of a preset pair never yields, so the pair stays atomic.
        stb_d     = 1'b1;
        stb_rnw_d = 1'b0;
        stb_rs_d  = 1'b1;
        stb_di_d  = preset_data;
        if (idx_q == LastIdx) begin
          pst_d    = PIdle;
          done_p_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
          pst_d = PAddr;
        end
      end else if (rest_q == OwnCpu && cpu_req) begin
        sel = OwnCpu;
      end else if (rest_q == OwnPlus && plus_en && plus_req) begin
        sel = OwnPlus;
      end else if (cpu_req) begin
        sel = OwnCpu;
      end else if (plus_en && plus_req) begin
        sel = OwnPlus;
      end else if (pst_q == PAddr) begin
        stb_d       = 1'b1;
        stb_rnw_d   = 1'b0;
        stb_di_d    = {4'h0, idx_q};
        cur_addr_d  = {1'b0, idx_q};
        cur_valid_d = 1'b1;
        pst_d       = PData;
      end
    end

    rq_rs  = (sel == OwnPlus) ? plus_rs   : cpu_rs;
    rq_rnw = (sel == OwnPlus) ? plus_rnw  : cpu_rnw;
    rq_di  = (sel == OwnPlus) ? plus_di   : cpu_di;
    sh_sel = (sel == OwnPlus) ? sh_plus_q : sh_cpu_q;

    if (sel != OwnNone) begin
      stb_d = 1'b1;
      if (!rq_rs) begin
        stb_rnw_d   = 1'b0;
        stb_di_d    = rq_di;
        cur_addr_d  = rq_di[4:0];
        cur_valid_d = 1'b1;
        give_ack    = 1'b1;
        if (sel == OwnPlus) sh_plus_d = rq_di[4:0];
        else                sh_cpu_d  = rq_di[4:0];
      end else if (!cur_valid_q || sh_sel != cur_addr_q) begin
        // Latch moved by someone else: reselect now, access in the owner's next slot.
        stb_rnw_d   = 1'b0;
        stb_di_d    = {3'b000, sh_sel};
        cur_addr_d  = sh_sel;
        cur_valid_d = 1'b1;
        rest_d      = sel;
      end else begin
        stb_rnw_d = rq_rnw;
        stb_rs_d  = 1'b1;
        stb_di_d  = rq_di;
        rd_p_d    = rq_rnw;
        give_ack  = 1'b1;
      end
    end

    ack_cpu_p_d  = give_ack && (sel == OwnCpu);
    ack_plus_p_d = give_ack && (sel == OwnPlus);
  end

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      pst_q        <= PIdle;
      rest_q       <= OwnNone;
      idx_q        <= 4'd0;
      sh_cpu_q     <= 5'd0;
      sh_plus_q    <= 5'd0;
      cur_addr_q   <= 5'd0;
      cur_valid_q  <= 1'b0;
      stb_q        <= 1'b0;
      stb_rnw_q    <= 1'b1;
      stb_rs_q     <= 1'b0;
      stb_di_q     <= 8'h00;
      ack_cpu_p_q  <= 1'b0;
      ack_plus_p_q <= 1'b0;
      rd_p_q       <= 1'b0;
      done_p_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      plus_ack_q   <= 1'b0;
      done_q       <= 1'b0;
      cpu_do_q     <= 8'h00;
      plus_do_q    <= 8'h00;
    end else begin
      pst_q        <= pst_d;
      rest_q       <= rest_d;
      idx_q        <= idx_d;
      sh_cpu_q     <= sh_cpu_d;
      sh_plus_q    <= sh_plus_d;
      cur_addr_q   <= cur_addr_d;
      cur_valid_q  <= cur_valid_d;
      stb_q        <= stb_d;
      stb_rnw_q    <= stb_rnw_d;
      stb_rs_q     <= stb_rs_d;
      stb_di_q     <= stb_di_d;
      ack_cpu_p_q  <= ack_cpu_p_d;
      ack_plus_p_q <= ack_plus_p_d;
      rd_p_q       <= rd_p_d;
      done_p_q     <= done_p_d;
      cpu_ack_q    <= ack_cpu_p_q;
      plus_ack_q   <= ack_plus_p_q;
      done_q       <= done_p_q;
      if (ack_cpu_p_q && rd_p_q)  cpu_do_q  <= crtc_do;
      if (ack_plus_p_q && rd_p_q) plus_do_q <= crtc_do;
    end
  end

  assign crtc_enable = stb_q;
  assign crtc_ncs    = ~stb_q;
  assign crtc_rnw    = stb_rnw_q;
  assign crtc_rs     = stb_rs_q;
  assign crtc_di     = stb_di_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_do      = cpu_do_q;
  assign plus_ack    = plus_ack_q;
  assign plus_do     = plus_do_q;
  assign preset_busy = (pst_q != PIdle);
  assign preset_done = done_q;
  assign preset_idx  = idx_q;

endmodule
